alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Arbitrating sequencer that shares one combinational 6-bit ALU datapath (XOR, AND, OR, ADD) between two requesters on the Basys3 ALU design. Each requester presents operands and an opcode with a valid/ready handshake. The block grants one requester at a time round-robin, registers operands, evaluates the ALU and returns a tagged result on a single response channel with backpressure. It sits between the switch/button front-end (requester 0), the self-test pattern generator (requester 1) and the LED/seven-segment display logic.

## Interface
Parameters:
- WIDTH, 6, operand and result width in bits

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  2  requester 0 opcode: 00 XOR, 01 AND, 10 OR, 11 ADD
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- rsp_valid  out  1  response holds a result
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester index that owns the result
- rsp_result  out  WIDTH  ALU result
- rsp_carry  out  1  carry out for ADD, 0 for logic ops
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- IDLE:
  - If any reqN_valid is high, grant one requester and assert its reqN_ready combinationally in the same cycle.
  - Latch a, b, op and id into operand registers, then go to EXEC.
- Arbitration:
  - With one requester valid, that requester wins.
  - With both valid, the requester that was not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first contention.
  - The pointer updates only on a grant.
- EXEC: the ALU evaluates the registered operands. Result, carry and id are registered into the response registers. Go to RESP.
- RESP:
  - rsp_valid is high.
  - On rsp_valid && rsp_ready, return to IDLE.
  - Otherwise hold, with all rsp_* outputs stable.
- Arithmetic:
  - ADD gives result = (a + b) mod 2^WIDTH, and carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - XOR, AND and OR are per-bit, with carry = 0.
- reqN_ready is never high outside IDLE. The block accepts only one request at a time, and never grants both requesters in the same cycle.
- A requester may change or drop its inputs while not granted, with no effect on the block.
- Reset mid-operation:
  - The in-flight operation is discarded.
  - rsp_valid drops immediately (asynchronous reset).
  - The pointer returns to 1.

## Timing
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0.
  - busy=0, req0_ready=0, req1_ready=0.
  - Operand registers are 0, and the last-grant pointer is 1.
- Grant in cycle T (reqN_valid && reqN_ready):
  - EXEC in T+1.
  - rsp_valid first high in T+2.
  - Latency is 2 cycles from acceptance to response.
- With rsp_ready tied high, throughput is one operation per 3 cycles (IDLE, EXEC, RESP).
- A response accepted in cycle T returns the FSM to IDLE in T+1, where the next grant can occur. There is no same-cycle response-to-grant bypass.
- A requester deasserting valid in the grant cycle is not allowed. The handshake completes whenever valid && ready.
- busy goes high the cycle after a grant and low the cycle after the response handshake.

## Structure
- Shared package alu_pkg holds:
  - the opcode constants OP_XOR=2'b00, OP_AND=2'b01, OP_OR=2'b10, OP_ADD=2'b11;
  - the state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - the WIDTH default.
- Sub-module alu_core is purely combinational. Its ports are a, b, op in and result, carry out. It is instantiated once inside alu_share_ctrl.
- The arbiter, FSM and registers live in alu_share_ctrl.

## Test plan
- Reset then single request: req0 with a=6'b101010, b=6'b110011, op=XOR. Required: req0_ready high in the grant cycle, then 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=6'b011001, rsp_carry=0.
- ADD with overflow: req1 with a=6'd40, b=6'd30, op=ADD. Required: rsp_result=6'd6, rsp_carry=1, rsp_id=1.
- Contention after reset: both valid continuously with rsp_ready=1. Required: grants alternate 0,1,0,1, and each grant is 3 cycles after the previous one.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP with req0_valid high. Required: rsp_* stable, req0_ready=0 throughout, busy=1. After rsp_ready=1, req0 is granted the following cycle.
- AND/OR check: a=6'h3C, b=6'h0F. Required: AND gives 6'h0C and OR gives 6'h3F, both with rsp_carry=0.
- Reset mid-operation: assert rst_n=0 during EXEC. Required: rsp_valid=0 and busy=0 immediately. After release, both requesters valid gives the grant to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes, FSM state encoding and default datapath width
package alu_pkg;
    localparam int DEFAULT_WIDTH = 6;
    localparam logic [1:0] OP_XOR = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: two requester channels plus one tagged response channel
// Ports: req0_*/req1_* valid/ready with a, b, op; rsp_* valid/ready with id, result, carry.
// slave modport faces the controller, master modport faces requesters and consumer.
interface alu_share_ctrl_if
    import alu_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH);
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [1:0]       req0_op;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [1:0]       req1_op;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [WIDTH-1:0] rsp_result;
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
    );
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_carry
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational XOR/AND/OR/ADD datapath
// Ports: a, b operands; op opcode; result WIDTH-bit output; carry set only by ADD overflow.
module alu_core
    import alu_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH)
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);
    logic [WIDTH:0] sum;
    assign sum = {1'b0, a} + {1'b0, b};
    always_comb begin
        result = op == OP_XOR ? a ^ b :
                 op == OP_AND ? a & b :
                 op == OP_OR  ? a | b : sum[WIDTH-1:0];
        carry  = op == OP_ADD && sum[WIDTH];
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one ALU between two requesters
// Ports: clk, rst_n (async active-low); bus slave modport with req0/req1/rsp channels;
// busy high whenever an operation is in flight (EXEC or RESP).
module alu_share_ctrl
    import alu_pkg::*;
#(parameter int WIDTH = DEFAULT_WIDTH)
(
    input  logic            clk,
    input  logic            rst_n,
    alu_share_ctrl_if.slave bus,
    output logic            busy
);
    state_t           state, state_n;
    logic             last, grant0, grant1, id_q, alu_carry;
    logic [WIDTH-1:0] a_q, b_q, alu_result;
    logic [1:0]       op_q;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .a(a_q), .b(b_q), .op(op_q), .result(alu_result), .carry(alu_carry)
    );

    // On contention the requester not granted last wins; last=1 favours requester 0.
    always_comb begin
        grant1  = rst_n && state == IDLE && bus.req1_valid && (!bus.req0_valid || !last);
        grant0  = rst_n && state == IDLE && bus.req0_valid && !grant1;
        state_n = state == IDLE ? ((grant0 || grant1) ? EXEC : IDLE) :
                  state == EXEC ? RESP :
                  (state == RESP && !bus.rsp_ready) ? RESP : IDLE;
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = state == RESP;
    assign busy           = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last           <= 1'b1;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            id_q           <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
        end else begin
            state <= state_n;
            if (grant0 || grant1) begin
                a_q  <= grant1 ? bus.req1_a  : bus.req0_a;
                b_q  <= grant1 ? bus.req1_b  : bus.req0_b;
                op_q <= grant1 ? bus.req1_op : bus.req0_op;
                id_q <= grant1;
                last <= grant1;
            end
            if (state == EXEC) begin
                bus.rsp_id     <= id_q;
                bus.rsp_result <= alu_result;
                bus.rsp_carry  <= alu_carry;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed vectors plus a transaction-level reference model checked every cycle
module tb_alu_share_ctrl;
    import alu_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   total = 0;
    int   passed = 0;

    alu_share_ctrl_if #(.WIDTH(6)) bus ();
    alu_share_ctrl #(.WIDTH(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    endtask

    // Reference: result as plain integer arithmetic, carry = sum reaches 64.
    function automatic logic [6:0] ref_alu(input int a, input int b, input logic [1:0] op);
        int r;
        case (op)
            2'b00:   r = a ^ b;
            2'b01:   r = a & b;
            2'b10:   r = a | b;
            default: r = a + b;
        endcase
        return {1'(r >= 64), 6'(r % 64)};
    endfunction

    // Model: one op in flight at a time; age 1 = being computed, age >= 2 = response offered.
    bit         m_busy = 0;
    int         m_age = 0;
    bit         m_last = 1;
    logic       m_id;
    logic [5:0] m_res;
    logic       m_carry;

    always @(negedge clk) begin
        int w;
        if (!rst_n) begin
            m_busy = 0;
            m_last = 1;
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_id", bus.rsp_id, 0);
            chk("rst_rsp_result", bus.rsp_result, 0);
            chk("rst_rsp_carry", bus.rsp_carry, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req0_ready", bus.req0_ready, 0);
            chk("rst_req1_ready", bus.req1_ready, 0);
        end else begin
            w = -1;
            if (!m_busy)
                w = (bus.req0_valid && bus.req1_valid) ? (m_last ? 0 : 1) :
                    bus.req0_valid ? 0 : bus.req1_valid ? 1 : -1;
            chk("busy", busy, 32'(m_busy));
            chk("req0_ready", bus.req0_ready, 32'(w == 0));
            chk("req1_ready", bus.req1_ready, 32'(w == 1));
            chk("rsp_valid", bus.rsp_valid, 32'(m_busy && m_age >= 2));
            if (m_busy && m_age >= 2) begin
                chk("rsp_id", bus.rsp_id, 32'(m_id));
                chk("rsp_result", bus.rsp_result, 32'(m_res));
                chk("rsp_carry", bus.rsp_carry, 32'(m_carry));
            end
            if (w >= 0) begin
                m_busy = 1;
                m_age  = 1;
                m_last = w[0];
                m_id   = w[0];
                {m_carry, m_res} = w == 1 ? ref_alu(int'(bus.req1_a), int'(bus.req1_b), bus.req1_op)
                                          : ref_alu(int'(bus.req0_a), int'(bus.req0_b), bus.req0_op);
            end else if (m_busy) begin
                if (m_age >= 2 && bus.rsp_ready) m_busy = 0;
                else m_age++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input logic [5:0] a, input logic [5:0] b, input logic [1:0] op);
        if (n == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end
    endtask

    // Single request from grant to accepted response, checking literal results in RESP.
    task automatic single(input string name, input int n, input logic [5:0] a, input logic [5:0] b,
                          input logic [1:0] op, input logic [5:0] res, input logic carry);
        drive(n, a, b, op);
        #1;
        chk({name, "_grant"}, n == 0 ? bus.req0_ready : bus.req1_ready, 1);
        tick;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick;
        chk({name, "_valid"}, bus.rsp_valid, 1);
        chk({name, "_id"}, bus.rsp_id, 32'(n));
        chk({name, "_result"}, bus.rsp_result, res);
        chk({name, "_carry"}, bus.rsp_carry, carry);
        tick;
    endtask

    initial begin
        int gid[$];
        int gcy[$];
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
        bus.rsp_ready = 1;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;

        single("xor", 0, 6'b101010, 6'b110011, OP_XOR, 6'b011001, 1'b0);
        single("add_ovf", 1, 6'd40, 6'd30, OP_ADD, 6'd6, 1'b1);

        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            drive(0, 6'(c), 6'(c + 7), OP_ADD);
            drive(1, 6'(c * 5), 6'h15, OP_XOR);
            #1;
            if (bus.req0_ready) begin gid.push_back(0); gcy.push_back(c); end
            if (bus.req1_ready) begin gid.push_back(1); gcy.push_back(c); end
            tick;
        end
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        chk("cont_count", gid.size(), 4);
        for (int i = 0; i < 4 && i < gid.size(); i++) begin
            chk("cont_id", gid[i], i % 2);
            chk("cont_cycle", gcy[i], 3 * i);
        end

        bus.rsp_ready = 0;
        drive(0, 6'd5, 6'd9, OP_OR);
        #1;
        chk("bp_grant", bus.req0_ready, 1);
        tick;
        tick;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_result", bus.rsp_result, 6'd13);
            chk("bp_id", bus.rsp_id, 0);
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_busy", busy, 1);
            tick;
        end
        bus.rsp_ready = 1;
        tick;
        chk("bp_regrant", bus.req0_ready, 1);
        tick;
        bus.req0_valid = 0;
        tick;
        tick;

        single("and", 0, 6'h3C, 6'h0F, OP_AND, 6'h0C, 1'b0);
        single("or", 0, 6'h3C, 6'h0F, OP_OR, 6'h3F, 1'b0);

        drive(1, 6'd33, 6'd44, OP_ADD);
        #1;
        chk("rst_mid_grant", bus.req1_ready, 1);
        tick;
        bus.req1_valid = 0;
        #2;
        chk("rst_mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", bus.rsp_valid, 0);
        @(negedge clk);
        tick;
        rst_n = 1'b1;
        drive(0, 6'd1, 6'd2, OP_AND);
        drive(1, 6'd3, 6'd4, OP_OR);
        #1;
        chk("rst_after_r0", bus.req0_ready, 1);
        chk("rst_after_r1", bus.req1_ready, 0);
        tick;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        repeat (3) tick;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
